// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : sram_bus_arbiter
// Purpose  : Shares one SRAM-like port between the I-fetch and D requesters.
//            D has priority, and the grant stays locked until the address
//            handshake completes. Data returns are routed back in issue order.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sram_bus_arbiter #(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 3
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             i_req,
  input  logic             i_wr,
  input  logic [1:0]       i_size,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_wdata,
  output logic             i_addr_ok,
  output logic             i_data_ok,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [1:0]       d_size,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic             d_addr_ok,
  output logic             d_data_ok,
  output logic [31:0]      d_rdata,
  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  input  logic [31:0]      m_rdata,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [MAX_OUT-1:0] fifo_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full, empty, push, pop, head, gnt_i, gnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(MAX_OUT));
  assign head  = fifo_q[rptr_q];
  assign pop   = m_data_ok & ~empty & ~reset;

  always_comb begin
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A pop from a full FIFO frees a slot in the same cycle.
        if (!reset && (!full || pop)) begin
          if (d_req)      gnt_d = 1'b1;
          else if (i_req) gnt_i = 1'b1;
        end
        if (gnt_d && !m_addr_ok)      state_d = LOCK_D;
        else if (gnt_i && !m_addr_ok) state_d = LOCK_I;
      end
      LOCK_I: begin
        gnt_i = ~reset;
        if (m_addr_ok) state_d = IDLE;
      end
      LOCK_D: begin
        gnt_d = ~reset;
        if (m_addr_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_req   = (gnt_i & i_req) | (gnt_d & d_req);
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = '0;
    m_wdata = '0;
    if (gnt_d) begin
      m_wr    = d_wr;
      m_size  = d_size;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (gnt_i) begin
      m_wr    = i_wr;
      m_size  = i_size;
      m_addr  = i_addr;
      m_wdata = i_wdata;
    end
  end

  assign push      = m_addr_ok & m_req;
  assign i_addr_ok = push & gnt_i;
  assign d_addr_ok = push & gnt_d;
  assign i_data_ok = pop & ~head;
  assign d_data_ok = pop & head;
  assign i_rdata   = i_data_ok ? m_rdata : '0;
  assign d_rdata   = d_data_ok ? m_rdata : '0;

  always_comb begin
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      fifo_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      if (push) fifo_q[wptr_q] <= gnt_d;
    end
  end

  assign out_cnt = cnt_q;
  assign busy    = (cnt_q != '0) || (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Module   : tb_sram_bus_arbiter
// Purpose  : Directed self-checking bench for sram_bus_arbiter.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_bus_arbiter;

  logic        Clk = 1'b0;
  logic        reset;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size, m_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [2:0]  out_cnt;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_stray  = 0;
  int n_drop   = 0;
  logic pend_i, pend_d;

  sram_bus_arbiter #(.MAX_OUT(2), .CNT_W(3)) dut (
    .Clk(Clk), .reset(reset),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .out_cnt(out_cnt), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Protocol monitors: stray data returns and requests dropped before addr_ok.
  always @(posedge Clk) begin
    if (reset) begin
      pend_i <= 1'b0;
      pend_d <= 1'b0;
    end else begin
      if (m_data_ok && out_cnt == 3'd0) n_stray <= n_stray + 1;
      if ((pend_i && !i_req) || (pend_d && !d_req)) n_drop <= n_drop + 1;
      pend_i <= i_req && !i_addr_ok;
      pend_d <= d_req && !d_addr_ok;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1ns after the rising edge; checks run 2ns later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = '0; i_wdata = '0;
    d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = '0; d_wdata = '0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    step(); step();
    reset = 1'b0;
    #2;
    check("rst_cnt", 32'(out_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mreq", 32'(m_req), 32'd0);
    check("rst_aok", 32'({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}), 32'd0);

    // Simultaneous request: D first, then I; data returns in issue order.
    step();
    d_req = 1; d_addr = 32'hBFAF_F000; d_size = 2'd1;
    i_req = 1; i_addr = 32'hBFC0_0000; i_size = 2'd2;
    m_addr_ok = 1;
    #2;
    check("t1_d_aok", 32'(d_addr_ok), 32'd1);
    check("t1_i_aok0", 32'(i_addr_ok), 32'd0);
    check("t1_maddr_d", m_addr, 32'hBFAF_F000);
    check("t1_msize_d", 32'(m_size), 32'd1);
    step();
    d_req = 0;
    #2;
    check("t1_i_aok", 32'(i_addr_ok), 32'd1);
    check("t1_maddr_i", m_addr, 32'hBFC0_0000);
    check("t1_msize_i", 32'(m_size), 32'd2);
    step();
    i_req = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'h11;
    #2;
    check("t1_cnt2", 32'(out_cnt), 32'd2);
    check("t1_d_dok", 32'({d_data_ok, i_data_ok}), 32'b10);
    check("t1_d_rdata", d_rdata, 32'h11);
    check("t1_i_rdata0", i_rdata, 32'h0);
    step();
    m_rdata = 32'h22;
    #2;
    check("t1_i_dok", 32'({d_data_ok, i_data_ok}), 32'b01);
    check("t1_i_rdata", i_rdata, 32'h22);
    check("t1_d_rdata0", d_rdata, 32'h0);
    step();
    m_data_ok = 0;
    #2;
    check("t1_cnt0", 32'(out_cnt), 32'd0);

    // Grant lock on I while D arrives late.
    step();
    i_req = 1; i_addr = 32'h1000_0000;
    #2;
    check("t2_c1_maddr", m_addr, 32'h1000_0000);
    check("t2_c1_iaok", 32'(i_addr_ok), 32'd0);
    step();
    d_req = 1; d_addr = 32'h2000_0000;
    #2;
    check("t2_c2_maddr", m_addr, 32'h1000_0000);
    check("t2_c2_daok", 32'(d_addr_ok), 32'd0);
    check("t2_c2_locked", 32'({busy, out_cnt}), 32'b1000);
    step();
    #2;
    check("t2_c3_maddr", m_addr, 32'h1000_0000);
    check("t2_c3_daok", 32'(d_addr_ok), 32'd0);
    step();
    m_addr_ok = 1;
    #2;
    check("t2_iaok", 32'({i_addr_ok, d_addr_ok}), 32'b10);
    step();
    i_req = 0;
    #2;
    check("t2_daok", 32'({i_addr_ok, d_addr_ok}), 32'b01);
    check("t2_maddr_d", m_addr, 32'h2000_0000);
    step();
    d_addr = 32'h3000_0000;
    #2;
    // FIFO now full (I, D outstanding): D held off.
    check("t3_cnt_full", 32'(out_cnt), 32'd2);
    check("t3_mreq_full", 32'(m_req), 32'd0);
    check("t3_daok_full", 32'(d_addr_ok), 32'd0);
    step();
    m_data_ok = 1; m_rdata = 32'hA1;
    #2;
    check("t3_mreq_pop", 32'(m_req), 32'd1);
    check("t3_daok_pop", 32'(d_addr_ok), 32'd1);
    check("t3_idok_pop", 32'({i_data_ok, d_data_ok}), 32'b10);
    step();
    d_req = 0; m_addr_ok = 0; m_rdata = 32'hA2;
    #2;
    check("t3_cnt_same", 32'(out_cnt), 32'd2);
    check("t3_dok1", 32'({i_data_ok, d_data_ok}), 32'b01);
    step();
    m_rdata = 32'hA3;
    #2;
    check("t3_dok2", 32'({i_data_ok, d_data_ok}), 32'b01);
    check("t3_drd2", d_rdata, 32'hA3);
    step();
    m_data_ok = 0;
    #2;
    check("t3_cnt0", 32'(out_cnt), 32'd0);

    // Pointer wrap: alternating I/D transactions.
    for (int k = 0; k < 6; k++) begin
      step();
      m_data_ok = 0; m_addr_ok = 1;
      if (k % 2 == 0) begin i_req = 1; i_addr = 32'h4000_0000 + k; end
      else begin d_req = 1; d_addr = 32'h5000_0000 + k; end
      #2;
      check("t4_aok", 32'({i_addr_ok, d_addr_ok}), (k % 2 == 0) ? 32'b10 : 32'b01);
      step();
      i_req = 0; d_req = 0; m_addr_ok = 0;
      m_data_ok = 1; m_rdata = 32'h100 + k;
      #2;
      check("t4_cnt", 32'(out_cnt), 32'd1);
      check("t4_dok", 32'({i_data_ok, d_data_ok}), (k % 2 == 0) ? 32'b10 : 32'b01);
      check("t4_rdata", (k % 2 == 0) ? i_rdata : d_rdata, 32'h100 + k);
    end
    step();
    m_data_ok = 0;

    // Reset with two transactions in flight.
    d_req = 1; d_addr = 32'h6000_0000; m_addr_ok = 1;
    step();
    d_req = 0; i_req = 1; i_addr = 32'h7000_0000;
    step();
    i_req = 0; m_addr_ok = 0;
    #2;
    check("t5_cnt2", 32'(out_cnt), 32'd2);
    reset = 1;
    step();
    reset = 0; m_data_ok = 1; m_rdata = 32'hDEAD;
    #2;
    check("t5_dok", 32'({i_data_ok, d_data_ok}), 32'b00);
    check("t5_cnt0", 32'(out_cnt), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    step();
    m_data_ok = 0;

    // Write forwarded unchanged.
    d_req = 1; d_wr = 1; d_size = 2'd0; d_addr = 32'h8000_0010; d_wdata = 32'h0000_5A00;
    m_addr_ok = 1;
    #2;
    check("t6_mwr", 32'(m_wr), 32'd1);
    check("t6_msize", 32'(m_size), 32'd0);
    check("t6_mwdata", m_wdata, 32'h0000_5A00);
    check("t6_maddr", m_addr, 32'h8000_0010);
    check("t6_daok", 32'(d_addr_ok), 32'd1);
    step();
    d_req = 0; d_wr = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = '0;
    #2;
    check("t6_dok", 32'({i_data_ok, d_data_ok}), 32'b01);
    step();
    m_data_ok = 0;
    step();

    check("mon_stray", 32'(n_stray), 32'd1);
    check("mon_drop", 32'(n_drop), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
